// File: rtl/sram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Package  : sram_arb_pkg
// Purpose  : Shared types and constants for the SRAM round-robin arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package sram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    localparam int NUM_REQ = 2;

    // With two ports, round-robin reduces to "the port that did not win last".
    function automatic logic other_port(input logic port);
        return ~port;
    endfunction

endpackage : sram_arb_pkg
`default_nettype wire

// File: rtl/sram_arbiter_if.sv
`default_nettype none
// ============================================================================
// Interface : sram_arbiter_if
// Purpose   : Valid/ready memory bus used by the requesters and by the SRAM.
// Revision  : 1.0 - initial release
// ============================================================================
interface sram_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);

    logic                  valid;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   wstrb;
    logic [DATA_W-1:0]     rdata;
    logic                  ready;

    modport master (
        output valid,
        output addr,
        output wdata,
        output wstrb,
        input  rdata,
        input  ready
    );

    modport slave (
        input  valid,
        input  addr,
        input  wdata,
        input  wstrb,
        output rdata,
        output ready
    );

endinterface : sram_arbiter_if
`default_nettype wire

// File: rtl/sram_arb_rr.sv
`default_nettype none
// ============================================================================
// Module   : sram_arb_rr
// Purpose  : Combinational 2-way round-robin picker.
// Revision : 1.0 - initial release
// ============================================================================
module sram_arb_rr
    import sram_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic               last_grant_i,
    output logic               grant_idx_o,
    output logic               any_o
);

    always_comb begin
        any_o       = |valid_i;
        grant_idx_o = 1'b0;
        case (valid_i)
            2'b01:   grant_idx_o = 1'b0;
            2'b10:   grant_idx_o = 1'b1;
            2'b11:   grant_idx_o = other_port(last_grant_i);
            default: grant_idx_o = 1'b0;
        endcase
    end

endmodule : sram_arb_rr
`default_nettype wire

// File: rtl/sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sram_arbiter
// Purpose  : Shares a single-port SRAM between instruction fetch (req0) and
//            load/store (req1); one access in flight, 1-cycle ready per port.
//            Define SRAM_ARB_PERF_EN to add grant/conflict counters.
// Revision : 1.0 - initial release
// ============================================================================
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic           clk,
    input  logic           rst,
    sram_arbiter_if.slave  req0,
    sram_arbiter_if.slave  req1,
    sram_arbiter_if.master mem
`ifdef SRAM_ARB_PERF_EN
    ,
    output logic [31:0]    grant0_cnt,
    output logic [31:0]    grant1_cnt,
    output logic [31:0]    conflict_cnt
`endif
);

    localparam int STRB_W = DATA_W / 8;

    arb_state_t          state_q, state_d;
    logic                last_grant_q, last_grant_d;
    logic                winner_q, winner_d;

    logic                mem_valid_q, mem_valid_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [STRB_W-1:0]   mem_wstrb_q, mem_wstrb_d;

    logic [DATA_W-1:0]   rdata0_q, rdata0_d;
    logic [DATA_W-1:0]   rdata1_q, rdata1_d;
    logic                ready0_q, ready0_d;
    logic                ready1_q, ready1_d;

    logic [NUM_REQ-1:0]  w_req_valid;
    logic                w_grant;
    logic                w_any;

    assign w_req_valid = {req1.valid, req0.valid};

    sram_arb_rr u_rr (
        .valid_i      (w_req_valid),
        .last_grant_i (last_grant_q),
        .grant_idx_o  (w_grant),
        .any_o        (w_any)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            winner_q     <= 1'b0;
            mem_valid_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_wstrb_q  <= '0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
            ready0_q     <= 1'b0;
            ready1_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            winner_q     <= winner_d;
            mem_valid_q  <= mem_valid_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_wstrb_q  <= mem_wstrb_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
            ready0_q     <= ready0_d;
            ready1_q     <= ready1_d;
        end
    end

    // The mem_* request registers are only loaded in IDLE, so they hold
    // steady for the whole ISSUE..RESP window.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        winner_d     = winner_q;
        mem_valid_d  = mem_valid_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_wstrb_d  = mem_wstrb_q;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
        ready0_d     = ready0_q;
        ready1_d     = ready1_q;

        case (state_q)
            IDLE: begin
                if (w_any) begin
                    winner_d     = w_grant;
                    last_grant_d = w_grant;
                    mem_valid_d  = 1'b1;
                    mem_addr_d   = w_grant ? req1.addr  : req0.addr;
                    mem_wdata_d  = w_grant ? req1.wdata : req0.wdata;
                    mem_wstrb_d  = w_grant ? req1.wstrb : req0.wstrb;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                mem_valid_d = 1'b0;
                state_d     = WAIT;
            end
            WAIT: begin
                if (mem.ready) begin
                    if (winner_q) begin
                        rdata1_d = mem.rdata;
                        ready1_d = 1'b1;
                    end else begin
                        rdata0_d = mem.rdata;
                        ready0_d = 1'b1;
                    end
                    state_d = RESP;
                end
            end
            RESP: begin
                ready0_d = 1'b0;
                ready1_d = 1'b0;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign mem.valid  = mem_valid_q;
    assign mem.addr   = mem_addr_q;
    assign mem.wdata  = mem_wdata_q;
    assign mem.wstrb  = mem_wstrb_q;

    assign req0.rdata = rdata0_q;
    assign req0.ready = ready0_q;
    assign req1.rdata = rdata1_q;
    assign req1.ready = ready1_q;

`ifdef SRAM_ARB_PERF_EN
    logic [NUM_REQ-1:0]  w_served;
    logic                w_conflict;
    logic                w_grant_evt;
    logic [31:0]         grant0_cnt_q;
    logic [31:0]         grant1_cnt_q;
    logic [31:0]         conflict_cnt_q;

    // A port counts as served from its grant cycle through its RESP cycle.
    always_comb begin
        w_grant_evt = (state_q == IDLE) && w_any;
        w_served    = '0;
        if (state_q == IDLE) begin
            if (w_any) begin
                w_served[w_grant] = 1'b1;
            end
        end else begin
            w_served[winner_q] = 1'b1;
        end
        w_conflict = |(w_req_valid & ~w_served);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grant0_cnt_q   <= '0;
            grant1_cnt_q   <= '0;
            conflict_cnt_q <= '0;
        end else begin
            if (w_grant_evt && !w_grant) begin
                grant0_cnt_q <= grant0_cnt_q + 32'd1;
            end
            if (w_grant_evt && w_grant) begin
                grant1_cnt_q <= grant1_cnt_q + 32'd1;
            end
            if (w_conflict) begin
                conflict_cnt_q <= conflict_cnt_q + 32'd1;
            end
        end
    end

    assign grant0_cnt   = grant0_cnt_q;
    assign grant1_cnt   = grant1_cnt_q;
    assign conflict_cnt = conflict_cnt_q;
`else
    // Counters absent; core behaviour is unchanged.
`endif

endmodule : sram_arbiter
`default_nettype wire

// File: tb/tb_sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_arbiter
// Purpose  : Arbiter over a behavioural SRAM (ready 2 cycles after valid),
//            checked by a per-port response scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_arbiter;

    typedef struct {
        logic [31:0] data;
        int          lo;
        int          hi;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_asserts = 0;
    int   n_fail = 0;
    int   c0;
    exp_t q0[$];
    exp_t q1[$];
    exp_t e0;
    exp_t e1;

    sram_arbiter_if #(.ADDR_W(32), .DATA_W(32)) req0_if ();
    sram_arbiter_if #(.ADDR_W(32), .DATA_W(32)) req1_if ();
    sram_arbiter_if #(.ADDR_W(32), .DATA_W(32)) mem_if ();

`ifdef SRAM_ARB_PERF_EN
    logic [31:0] g0_cnt;
    logic [31:0] g1_cnt;
    logic [31:0] cf_cnt;
`endif

    sram_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .req0         (req0_if),
        .req1         (req1_if),
        .mem          (mem_if)
`ifdef SRAM_ARB_PERF_EN
        ,
        .grant0_cnt   (g0_cnt),
        .grant1_cnt   (g1_cnt),
        .conflict_cnt (cf_cnt)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural SRAM; deliberately not reset so a late ready can follow rst.
    logic [31:0] sram [16];
    logic        pl_en;
    logic [3:0]  pl_idx;
    logic [31:0] pl_data;
    logic        s1_v;
    logic [31:0] s1_data;

    always @(posedge clk) begin
        if (pl_en) begin
            sram[pl_idx] <= pl_data;
        end else if (mem_if.valid === 1'b1) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_if.wstrb[b]) sram[mem_if.addr[5:2]][8*b +: 8] <= mem_if.wdata[8*b +: 8];
            end
        end
        s1_v <= (mem_if.valid === 1'b1);
        if (mem_if.valid === 1'b1) s1_data <= sram[mem_if.addr[5:2]];
        mem_if.ready <= s1_v;
        mem_if.rdata <= s1_data;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h required 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_cycle(input string tag, input exp_t e);
        if (e.lo == e.hi) chk(tag, cyc, e.lo);
        else chk(tag, (cyc >= e.lo && cyc <= e.hi) ? 32'd1 : 32'd0, 32'd1);
    endtask

    // Scoreboard: every ready pulse must match the oldest expectation of its port.
    always @(negedge clk) begin
        if (rst === 1'b0 && req0_if.ready === 1'b1) begin
            if (q0.size() == 0) begin
                chk("rdy0_unexpected", {31'd0, req0_if.ready}, 32'd0);
            end else begin
                e0 = q0.pop_front();
                chk("rdy0_rdata", req0_if.rdata, e0.data);
                chk_cycle("rdy0_cycle", e0);
            end
        end
        if (rst === 1'b0 && req1_if.ready === 1'b1) begin
            if (q1.size() == 0) begin
                chk("rdy1_unexpected", {31'd0, req1_if.ready}, 32'd0);
            end else begin
                e1 = q1.pop_front();
                chk("rdy1_rdata", req1_if.rdata, e1.data);
                chk_cycle("rdy1_cycle", e1);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int p, input logic v, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] s);
        if (p == 0) begin
            req0_if.valid = v; req0_if.addr = a; req0_if.wdata = d; req0_if.wstrb = s;
        end else begin
            req1_if.valid = v; req1_if.addr = a; req1_if.wdata = d; req1_if.wstrb = s;
        end
    endtask

    task automatic expect_rsp(input int p, input logic [31:0] d, input int lo, input int hi);
        exp_t e;
        e.data = d; e.lo = lo; e.hi = hi;
        if (p == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    // Waits for n ready pulses on port p, then returns just after the next edge.
    task automatic wait_rdy(input int p, input int n, input int budget, input string tag);
        int seen = 0;
        for (int i = 0; i < budget && seen < n; i++) begin
            @(negedge clk);
            if (((p == 0) ? req0_if.ready : req1_if.ready) === 1'b1) seen++;
        end
        chk(tag, seen, n);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_mem_valid"}, {31'd0, mem_if.valid}, 32'd0);
        chk({tag, "_mem_addr"},  mem_if.addr, 32'd0);
        chk({tag, "_mem_wdata"}, mem_if.wdata, 32'd0);
        chk({tag, "_mem_wstrb"}, {28'd0, mem_if.wstrb}, 32'd0);
        chk({tag, "_ready0"},    {31'd0, req0_if.ready}, 32'd0);
        chk({tag, "_ready1"},    {31'd0, req1_if.ready}, 32'd0);
        chk({tag, "_rdata0"},    req0_if.rdata, 32'd0);
        chk({tag, "_rdata1"},    req1_if.rdata, 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        pl_en = 1'b0; pl_idx = 4'd0; pl_data = 32'd0;
        set_req(0, 1'b0, 32'd0, 32'd0, 4'd0);
        set_req(1, 1'b0, 32'd0, 32'd0, 4'd0);

        tick(1);
        pl_en = 1'b1; pl_idx = 4'd0; pl_data = 32'hDEADBEEF;
        tick(1);
        pl_idx = 4'd4; pl_data = 32'hAABBCCDD;
        tick(1);
        pl_en = 1'b0;
        tick(1);
        @(negedge clk);
        chk_all_zero("reset");
        tick(1);
        rst = 1'b0;
        tick(1);

        // req1 partial write, then read back the merged word
        c0 = cyc;
        expect_rsp(1, 32'hAABBCCDD, c0 + 4, c0 + 4);
        set_req(1, 1'b1, 32'h10, 32'h12345678, 4'b0011);
        @(negedge clk);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk("wr_mem_addr",  mem_if.addr, 32'h10);
            chk("wr_mem_wdata", mem_if.wdata, 32'h12345678);
            chk("wr_mem_wstrb", {28'd0, mem_if.wstrb}, 32'h3);
        end
        chk("wr_ready1", {31'd0, req1_if.ready}, 32'd1);
        @(posedge clk);
        #1;
        set_req(1, 1'b0, 32'd0, 32'd0, 4'd0);
        tick(1);
        c0 = cyc;
        expect_rsp(1, 32'hAABB5678, c0 + 4, c0 + 4);
        set_req(1, 1'b1, 32'h10, 32'd0, 4'b0000);
        wait_rdy(1, 1, 10, "rd1_timeout");
        set_req(1, 1'b0, 32'd0, 32'd0, 4'd0);

        // req0 read with exact issue timing
        tick(1);
        c0 = cyc;
        expect_rsp(0, 32'hDEADBEEF, c0 + 4, c0 + 4);
        set_req(0, 1'b1, 32'h0, 32'd0, 4'b0000);
        @(negedge clk);
        chk("rd0_c0_mem_valid", {31'd0, mem_if.valid}, 32'd0);
        @(negedge clk);
        chk("rd0_c1_mem_valid", {31'd0, mem_if.valid}, 32'd1);
        @(negedge clk);
        chk("rd0_c2_mem_valid", {31'd0, mem_if.valid}, 32'd0);
        wait_rdy(0, 1, 10, "rd0_timeout");
        set_req(0, 1'b0, 32'd0, 32'd0, 4'd0);

        // Both valid right after reset: req0 first, then strict alternation
        do_reset();
        tick(1);
        c0 = cyc;
        expect_rsp(0, 32'hDEADBEEF, c0 + 4,  c0 + 4);
        expect_rsp(1, 32'hAABB5678, c0 + 9,  c0 + 9);
        expect_rsp(0, 32'hDEADBEEF, c0 + 14, c0 + 14);
        expect_rsp(1, 32'hAABB5678, c0 + 19, c0 + 19);
        set_req(0, 1'b1, 32'h0,  32'd0, 4'b0000);
        set_req(1, 1'b1, 32'h10, 32'd0, 4'b0000);
        wait_rdy(0, 2, 25, "alt0_timeout");
        set_req(0, 1'b0, 32'd0, 32'd0, 4'd0);
        wait_rdy(1, 1, 10, "alt1_timeout");
        set_req(1, 1'b0, 32'd0, 32'd0, 4'd0);

        // req0 streams continuously; req1 must still get in within 10 cycles
        tick(1);
        c0 = cyc;
        expect_rsp(0, 32'hDEADBEEF, c0 + 4,  c0 + 4);
        expect_rsp(0, 32'hDEADBEEF, c0 + 14, c0 + 14);
        expect_rsp(0, 32'hDEADBEEF, c0 + 19, c0 + 19);
        expect_rsp(0, 32'hDEADBEEF, c0 + 24, c0 + 24);
        set_req(0, 1'b1, 32'h0, 32'd0, 4'b0000);
        tick(2);
        expect_rsp(1, 32'hAABB5678, cyc, cyc + 10);
        set_req(1, 1'b1, 32'h10, 32'd0, 4'b0000);
        wait_rdy(1, 1, 12, "stream1_timeout");
        set_req(1, 1'b0, 32'd0, 32'd0, 4'd0);
        wait_rdy(0, 3, 20, "stream0_timeout");
        set_req(0, 1'b0, 32'd0, 32'd0, 4'd0);

        // Reset while waiting on the SRAM; the late mem_ready must be ignored
        tick(1);
        set_req(0, 1'b1, 32'h20, 32'hCAFEF00D, 4'b1111);
        tick(2);
        rst = 1'b1;
        set_req(0, 1'b0, 32'd0, 32'd0, 4'd0);
        tick(1);
        rst = 1'b0;
        @(negedge clk);
        chk_all_zero("midrst");
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("midrst_no_ready0", {31'd0, req0_if.ready}, 32'd0);
        end
        tick(1);

        // Winner drops valid mid-flight; access still completes
        c0 = cyc;
        expect_rsp(1, 32'hAABB5678, c0 + 4, c0 + 4);
        set_req(1, 1'b1, 32'h10, 32'd0, 4'b0000);
        tick(2);
        set_req(1, 1'b0, 32'd0, 32'd0, 4'd0);
        wait_rdy(1, 1, 8, "drop1_timeout");

        // Grant/conflict accounting: 3 req0 grants, 2 req1 grants, one overlap
        do_reset();
        tick(1);
`ifdef SRAM_ARB_PERF_EN
        chk("perf_g0_reset", g0_cnt, 32'd0);
        chk("perf_g1_reset", g1_cnt, 32'd0);
        chk("perf_cf_reset", cf_cnt, 32'd0);
`endif
        c0 = cyc;
        expect_rsp(0, 32'hDEADBEEF, c0 + 4, c0 + 4);
        set_req(0, 1'b1, 32'h0, 32'd0, 4'b0000);
        wait_rdy(0, 1, 10, "perf_a_timeout");
        set_req(0, 1'b0, 32'd0, 32'd0, 4'd0);
`ifdef SRAM_ARB_PERF_EN
        chk("perf_cf_solo", cf_cnt, 32'd0);
`endif
        c0 = cyc;
        expect_rsp(1, 32'hAABB5678, c0 + 4, c0 + 4);
        expect_rsp(0, 32'hDEADBEEF, c0 + 9, c0 + 9);
        set_req(0, 1'b1, 32'h0,  32'd0, 4'b0000);
        set_req(1, 1'b1, 32'h10, 32'd0, 4'b0000);
        wait_rdy(1, 1, 10, "perf_b1_timeout");
        set_req(1, 1'b0, 32'd0, 32'd0, 4'd0);
        wait_rdy(0, 1, 10, "perf_b0_timeout");
        set_req(0, 1'b0, 32'd0, 32'd0, 4'd0);
        c0 = cyc;
        expect_rsp(0, 32'hDEADBEEF, c0 + 4, c0 + 4);
        set_req(0, 1'b1, 32'h0, 32'd0, 4'b0000);
        wait_rdy(0, 1, 10, "perf_c_timeout");
        set_req(0, 1'b0, 32'd0, 32'd0, 4'd0);
        c0 = cyc;
        expect_rsp(1, 32'hAABB5678, c0 + 4, c0 + 4);
        set_req(1, 1'b1, 32'h10, 32'd0, 4'b0000);
        wait_rdy(1, 1, 10, "perf_d_timeout");
        set_req(1, 1'b0, 32'd0, 32'd0, 4'd0);
        tick(2);
`ifdef SRAM_ARB_PERF_EN
        chk("perf_grant0_cnt",   g0_cnt, 32'd3);
        chk("perf_grant1_cnt",   g1_cnt, 32'd2);
        chk("perf_conflict_cnt", cf_cnt, 32'd5);
`endif

        chk("sb_q0_drained", q0.size(), 32'd0);
        chk("sb_q1_drained", q1.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule : tb_sram_arbiter
`default_nettype wire
